// File: rtl/instr_loader.sv
// instr_loader: assembles a framed byte stream into 16-bit instruction words,
// writes them into instruction RAM, and holds the CPU until a frame with a
// good checksum has been loaded.
module instr_loader #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter bit         HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wen,
    output logic        cpu_hold,
    output logic        busy,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR_H = 3'd1;
    localparam logic [2:0] ST_ADDR_L = 3'd2;
    localparam logic [2:0] ST_CNT_H  = 3'd3;
    localparam logic [2:0] ST_CNT_L  = 3'd4;
    localparam logic [2:0] ST_DATA_H = 3'd5;
    localparam logic [2:0] ST_DATA_L = 3'd6;
    localparam logic [2:0] ST_CSUM   = 3'd7;

    logic [2:0]  state;
    logic [15:0] cur_addr;
    logic [15:0] count;
    logic [7:0]  sum;
    logic [7:0]  hi_byte;
    logic        accepted;
    logic        in_payload;

    // RAM writes are single-cycle, so the loader never applies backpressure.
    assign in_ready   = 1'b1;
    assign accepted   = in_valid && in_ready;
    assign busy       = (state != ST_IDLE);
    // Header and data bytes feed the checksum; SYNC and CSUM bytes do not.
    assign in_payload = (state >= ST_ADDR_H) && (state <= ST_DATA_L);

    // Running 8-bit checksum, cleared when a new frame starts.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            sum <= 8'h00;
        end else if (accepted) begin
            if (state == ST_IDLE && in_data == SYNC_BYTE)
                sum <= 8'h00;
            else if (in_payload)
                sum <= sum + in_data;
        end
    end

    // Frame parser: advances one state per accepted byte and issues RAM writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur_addr  <= 16'h0000;
            count     <= 16'h0000;
            hi_byte   <= 8'h00;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            mem_wen   <= 1'b0;
            cpu_hold  <= HOLD_AT_RESET;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            // NOTE: default the strobe low every cycle; only a DATA_L acceptance
            // raises it, which guarantees a single-cycle pulse.
            mem_wen <= 1'b0;
            if (accepted) begin
                case (state)
                    ST_IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state     <= ST_ADDR_H;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            cpu_hold  <= 1'b1;
                        end
                    end
                    ST_ADDR_H: begin
                        cur_addr[15:8] <= in_data;
                        state          <= ST_ADDR_L;
                    end
                    ST_ADDR_L: begin
                        cur_addr[7:0] <= in_data;
                        state         <= ST_CNT_H;
                    end
                    ST_CNT_H: begin
                        count[15:8] <= in_data;
                        state       <= ST_CNT_L;
                    end
                    ST_CNT_L: begin
                        count[7:0] <= in_data;
                        state      <= ({count[15:8], in_data} != 16'h0000) ? ST_DATA_H : ST_CSUM;
                    end
                    ST_DATA_H: begin
                        hi_byte <= in_data;
                        state   <= ST_DATA_L;
                    end
                    ST_DATA_L: begin
                        mem_wdata <= {hi_byte, in_data};
                        mem_addr  <= cur_addr;
                        mem_wen   <= 1'b1;
                        cur_addr  <= cur_addr + 16'd1;
                        count     <= count - 16'd1;
                        state     <= (count == 16'd1) ? ST_CSUM : ST_DATA_H;
                    end
                    ST_CSUM: begin
                        // Writes already issued stay in RAM; a bad frame only keeps the CPU held.
                        if (in_data == sum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table-driven frame vectors with a write scoreboard, plus
// hand-written sequences for hold-on-resync and reset mid-frame.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wen;
    logic        cpu_hold;
    logic        busy;
    logic        load_done;
    logic        load_err;

    instr_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected RAM writes: {addr, data}.
    logic [31:0] exp_q[$];
    int          wr_seen = 0;

    always @(negedge clk) begin
        if (!reset && mem_wen) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_addr, mem_wdata}, 32'hDEAD_DEAD);
            end else begin
                check("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        string        name;
        int           len;        // bytes excluding CSUM
        logic [127:0] bytes;      // byte i at [i*8 +: 8]
        logic [7:0]   csum_delta; // 0 = correct checksum
        bit           junk;       // send 00 FF before the frame
        int           gap_max;
        bit           exp_done;
        bit           exp_err;
        bit           exp_hold;
        int           exp_writes;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] get_byte(input logic [127:0] b, input int i);
        return b[i*8 +: 8];
    endfunction

    function automatic logic [127:0] pack_bytes(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8);
        logic [127:0] r = '0;
        r[0*8 +: 8] = b0; r[1*8 +: 8] = b1; r[2*8 +: 8] = b2;
        r[3*8 +: 8] = b3; r[4*8 +: 8] = b4; r[5*8 +: 8] = b5;
        r[6*8 +: 8] = b6; r[7*8 +: 8] = b7; r[8*8 +: 8] = b8;
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] addr;
        logic [15:0] cnt;
        logic [7:0]  cs;
        wr_seen = 0;
        if (v.junk) begin
            send_byte(8'h00, 0);
            send_byte(8'hFF, 0);
            check({v.name, "_junk_idle"}, {31'd0, busy}, 32'd0);
        end
        addr = {get_byte(v.bytes, 1), get_byte(v.bytes, 2)};
        cnt  = {get_byte(v.bytes, 3), get_byte(v.bytes, 4)};
        cs   = 8'h00;
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) cs = cs + get_byte(v.bytes, i);
            if (i >= 5 && ((i - 5) % 2) == 1) begin
                exp_q.push_back({addr + 16'((i - 5) / 2),
                                 get_byte(v.bytes, i - 1), get_byte(v.bytes, i)});
            end
            send_byte(get_byte(v.bytes, i), (v.gap_max > 0) ? $urandom_range(v.gap_max, 0) : 0);
            check({v.name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        end
        check({v.name, "_busy_mid"}, {31'd0, busy}, 32'd1);
        send_byte(cs + v.csum_delta, 0);
        @(posedge clk);
        #1;
        check({v.name, "_writes"},    wr_seen, v.exp_writes);
        check({v.name, "_count_hdr"}, 32'(cnt), v.exp_writes);
        check({v.name, "_queue_empty"}, exp_q.size(), 0);
        check({v.name, "_load_done"}, {31'd0, load_done}, {31'd0, v.exp_done});
        check({v.name, "_load_err"},  {31'd0, load_err},  {31'd0, v.exp_err});
        check({v.name, "_cpu_hold"},  {31'd0, cpu_hold},  {31'd0, v.exp_hold});
        check({v.name, "_busy_end"},  {31'd0, busy}, 32'd0);
        check({v.name, "_wen_idle"},  {31'd0, mem_wen}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},      {31'd0, busy}, 32'd0);
        check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
        check({tag, "_mem_wen"},   {31'd0, mem_wen}, 32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_load_err"},  {31'd0, load_err}, 32'd0);
        check({tag, "_cpu_hold"},  {31'd0, cpu_hold}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{"good2", 9, pack_bytes(8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD),
                    8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 2};
        vecs[1] = '{"badsum", 9, pack_bytes(8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD),
                    8'h01, 1'b0, 0, 1'b0, 1'b1, 1'b1, 2};
        vecs[2] = '{"wrap", 9, pack_bytes(8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02),
                    8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2};
        vecs[3] = '{"zero_cnt", 5, pack_bytes(8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00),
                    8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0};
        vecs[4] = '{"gaps", 9, pack_bytes(8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD),
                    8'h00, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2};
        vecs[5] = '{"sync_data", 7, pack_bytes(8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h00, 8'h00),
                    8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1};

        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // CPU is running after the last good frame; a new SYNC must stall it on the next cycle.
        check("running_before_sync", {31'd0, cpu_hold}, 32'd0);
        send_byte(8'hA5, 0);
        check("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
        check("done_cleared",    {31'd0, load_done}, 32'd0);
        check("busy_after_sync", {31'd0, busy}, 32'd1);

        // in_valid low holds everything.
        repeat (4) @(posedge clk);
        #1;
        check("idle_gap_busy", {31'd0, busy}, 32'd1);

        // Abandon the frame after ADDR_L with a reset.
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("midreset");

        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
